// File: rtl/song_player_if.sv
// Song ROM read port: the player drives the address, the ROM returns the word.
interface song_player_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/song_player.sv
// Note sequencer: fetches {dur,tone} words from a synchronous song ROM, times each
// note in duration ticks and drives a square-wave speaker output.
module song_player #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DUR_W     = 4,
  parameter int unsigned TONE_W    = 4,
  parameter int unsigned SONG_LEN  = 21,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned TICK_DIV  = 25000,
  parameter int unsigned HALF_BASE = 1000,
  parameter int unsigned HALF_STEP = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  song_player_if.master     rom,
  output logic              sound,
  output logic [TONE_W-1:0] cur_tone,
  output logic              playing,
  output logic              done
);

  localparam int unsigned WORD_W    = DUR_W + TONE_W;
  localparam int unsigned WAIT_W    = $clog2(ROM_LAT + 1);
  localparam int unsigned NOTE_MAX  = ((2 ** DUR_W) - 1) * TICK_DIV;
  localparam int unsigned NOTE_W    = $clog2(NOTE_MAX + 1);
  localparam int unsigned HALF_MAX  = HALF_BASE + ((2 ** TONE_W) - 1) * HALF_STEP;
  localparam int unsigned PH_W      = $clog2(HALF_MAX + 1);
  localparam int unsigned LAST_ADDR = SONG_LEN - 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [NOTE_W-1:0]   note_cnt, note_n;
  logic [PH_W-1:0]     ph_cnt, ph_n;
  logic [DUR_W-1:0]    cur_dur, dur_n;
  logic [TONE_W-1:0]   tone_n;
  logic                sound_n, done_n, end_song;

  logic [DUR_W-1:0]    word_dur_c;
  logic [TONE_W-1:0]   word_tone_c;
  logic [TONE_W-1:0]   tone_inv_c;
  logic [NOTE_W-1:0]   note_last_c;
  logic [PH_W-1:0]     half_last_c;

  assign rom.rom_addr = addr;
  assign word_dur_c   = rom.rom_data[WORD_W-1:TONE_W];
  assign word_tone_c  = rom.rom_data[TONE_W-1:0];

  // ~tone equals (2**TONE_W-1 - tone): number of steps below the highest tone
  assign tone_inv_c  = ~cur_tone;
  assign note_last_c = NOTE_W'(cur_dur) * NOTE_W'(TICK_DIV) - NOTE_W'(1);
  assign half_last_c = PH_W'(HALF_BASE) + PH_W'(tone_inv_c) * PH_W'(HALF_STEP) - PH_W'(1);

  // Next-state and next-output logic; stop and end-of-song override the per-state decisions
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    wait_n   = wait_cnt;
    note_n   = note_cnt;
    ph_n     = ph_cnt;
    dur_n    = cur_dur;
    tone_n   = cur_tone;
    sound_n  = sound;
    done_n   = 1'b0;
    end_song = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          addr_n  = '0;
          wait_n  = '0;
        end
      end
      S_FETCH: begin
        if (wait_cnt == WAIT_W'(ROM_LAT)) begin
          if (word_dur_c != '0) begin
            state_n = S_PLAY;
            dur_n   = word_dur_c;
            tone_n  = word_tone_c;
            note_n  = '0;
            ph_n    = '0;
            sound_n = 1'b0;
          end else begin
            end_song = 1'b1;
          end
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      S_PLAY: begin
        if (!pause) begin
          if (note_cnt == note_last_c) begin
            tone_n  = '0;
            sound_n = 1'b0;
            if (addr == ADDR_W'(LAST_ADDR)) begin
              end_song = 1'b1;
            end else begin
              state_n = S_FETCH;
              addr_n  = addr + ADDR_W'(1);
              wait_n  = '0;
            end
          end else begin
            note_n = note_cnt + NOTE_W'(1);
            if (cur_tone != '0) begin
              if (ph_cnt == half_last_c) begin
                ph_n    = '0;
                sound_n = ~sound;
              end else begin
                ph_n = ph_cnt + PH_W'(1);
              end
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (end_song) begin
      addr_n  = '0;
      wait_n  = '0;
      tone_n  = '0;
      sound_n = 1'b0;
      if (loop) begin
        state_n = S_FETCH;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end

    if (stop) begin
      state_n = S_IDLE;
      addr_n  = '0;
      tone_n  = '0;
      sound_n = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      wait_cnt <= '0;
      note_cnt <= '0;
      ph_cnt   <= '0;
      cur_dur  <= '0;
      cur_tone <= '0;
      sound    <= 1'b0;
      playing  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      wait_cnt <= wait_n;
      note_cnt <= note_n;
      ph_cnt   <= ph_n;
      cur_dur  <= dur_n;
      cur_tone <= tone_n;
      sound    <= sound_n;
      playing  <= (state_n != S_IDLE);
      done     <= done_n;
    end
  end

endmodule
